// File: rtl/instr_sequencer.sv
// Program sequencer: replays a loaded instruction store, inserting PAD NOPs after each word and DRAIN NOPs at the end.
// Define CYCLE_LIMIT_EN to enable the run-length watchdog (cycle_limit/timeout); otherwise timeout is held at 0.
module instr_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64,
    parameter int PAD   = 4,
    parameter int DRAIN = 4,
    parameter logic [WIDTH-1:0] NOP = 'h20,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic [AW:0]      prog_len,
    input  logic             start,
    input  logic             stall,
    output logic [WIDTH-1:0] instr_out,
    output logic             instr_valid,
    output logic [AW+1:0]    pc_out,
    output logic             busy,
    output logic             done,
    input  logic [15:0]      cycle_limit,
    output logic             timeout
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_PAD, S_DRAIN, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW:0]      index_q, index_d, len_q, len_d, next_idx, len_clamp;
    logic [15:0]      cnt_q, cnt_d;
    logic [AW+1:0]    pc_q, pc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;
    logic             idle_like, accept, advance, drain, finish, limit_hit;
    logic [WIDTH-1:0] store [DEPTH];

    assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept    = idle_like && start && !load_en;
    assign next_idx  = index_q + (AW+1)'(1);
    assign len_clamp = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    // Store has no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (load_en && idle_like) store[load_addr] <= load_data;
    end

`ifdef CYCLE_LIMIT_EN
    logic [15:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (accept)      cyc_d = '0;
        else if (busy_q) cyc_d = cyc_q + 16'd1;
    end

    assign limit_hit = busy_q && (cycle_limit != 16'd0) && (cyc_d >= cycle_limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_d;
    end
`else
    logic unused_limit;
    assign unused_limit = ^cycle_limit;
    assign limit_hit    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        advance   = 1'b0;
        drain     = 1'b0;
        finish    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    len_d     = len_clamp;
                    index_d   = '0;
                    pc_d      = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    valid_d   = 1'b1;
                    if (len_clamp != '0) begin
                        state_d = S_ISSUE;
                        instr_d = store[0];
                    end else if (DRAIN > 0) begin
                        state_d = S_DRAIN;
                        cnt_d   = 16'(DRAIN - 1);
                        instr_d = NOP;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!stall) begin
                    if (PAD > 0) begin
                        state_d = S_PAD;
                        cnt_d   = 16'(PAD - 1);
                        instr_d = NOP;
                        pc_d    = pc_q + (AW+2)'(4);
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (!stall) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 16'd1;
                        pc_d  = pc_q + (AW+2)'(4);
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!stall) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 16'd1;
                        pc_d  = pc_q + (AW+2)'(4);
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (advance) begin
            index_d = next_idx;
            if (next_idx < len_q) begin
                state_d = S_ISSUE;
                instr_d = store[next_idx[AW-1:0]];
                pc_d    = pc_q + (AW+2)'(4);
            end else begin
                drain = 1'b1;
            end
        end

        if (drain) begin
            if (DRAIN > 0) begin
                state_d = S_DRAIN;
                cnt_d   = 16'(DRAIN - 1);
                instr_d = NOP;
                pc_d    = pc_q + (AW+2)'(4);
            end else begin
                finish = 1'b1;
            end
        end

        // pc is left pointing one word past the final issued word.
        if (finish) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pc_d    = pc_q + (AW+2)'(4);
        end

        if (limit_hit) begin
            state_d   = S_DONE;
            valid_d   = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            pc_q      <= '0;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
endmodule
